// File: rtl/dual_issue_scheduler.sv
// Issue-stage scheduler: dual-issues decoded pairs, splits them on intra-pair
// conflicts and inserts bubbles on load-use hazards against last cycle's issue.

module dual_issue_scheduler #(
  parameter int IW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] a_instr,
  input  logic [IW-1:0] b_instr,
  input  logic [3:0]    a_type,
  input  logic [3:0]    b_type,
  input  logic [RW-1:0] a_rd,
  input  logic [RW-1:0] a_rs1,
  input  logic [RW-1:0] a_rs2,
  input  logic [RW-1:0] b_rd,
  input  logic [RW-1:0] b_rs1,
  input  logic [RW-1:0] b_rs2,
  input  logic          a_use_rs1,
  input  logic          a_use_rs2,
  input  logic          a_we,
  input  logic          b_use_rs1,
  input  logic          b_use_rs2,
  input  logic          b_we,
  input  logic          flush,
  input  logic          iss_ready,
  output logic          iss_a_valid,
  output logic          iss_b_valid,
  output logic [IW-1:0] iss_a_instr,
  output logic [IW-1:0] iss_b_instr,
  output logic [3:0]    iss_a_type,
  output logic [3:0]    iss_b_type,
  output logic [RW-1:0] iss_a_rd,
  output logic [RW-1:0] iss_b_rd,
  output logic          iss_a_we,
  output logic          iss_b_we,
  output logic [3:0]    hazard_a,
  output logic [3:0]    hazard_b,
  output logic [15:0]   bubble_cnt
);

  // Encodings shared with the enum_helpers instruction_t / hazard_signal_t types.
  typedef enum logic [3:0] {
    R_TYPE_i = 4'd0,  I_TYPE_i = 4'd1, LOAD_i   = 4'd2, S_TYPE_i = 4'd3,
    B_TYPE_i = 4'd4,  JAL_i    = 4'd5, JALR_i   = 4'd6, LUI_i    = 4'd7,
    AUIPC_i  = 4'd8,  ECALL_i  = 4'd9, FENCE_i  = 4'd10, NONE_i  = 4'd11
  } instruction_t;

  typedef enum logic [3:0] {
    A_STALL      = 4'd0,
    B_STALL      = 4'd1,
    STALL_FROM_A = 4'd2,
    NONE_h       = 4'd9
  } hazard_signal_t;

  typedef enum logic {PAIR, HOLD_B} state_t;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] instr;
    logic [3:0]    itype;
    logic [RW-1:0] rd;
    logic          we;
  } lane_t;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [3:0]    itype;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          use_rs1;
    logic          use_rs2;
    logic          we;
  } slot_t;

  localparam lane_t LANE_RST = '{valid: 1'b0, instr: '0, itype: NONE_i, rd: '0, we: 1'b0};
  localparam slot_t SLOT_RST = '{instr: '0, itype: NONE_i, rd: '0, rs1: '0, rs2: '0,
                                 use_rs1: 1'b0, use_rs2: 1'b0, we: 1'b0};

  function automatic logic writes_load(lane_t l, logic [RW-1:0] r);
    return l.valid && (l.itype == LOAD_i) && l.we && (l.rd == r);
  endfunction

  function automatic logic load_hit(slot_t s, lane_t la, lane_t lb);
    logic h1, h2;
    h1 = s.use_rs1 && (s.rs1 != '0) && (writes_load(la, s.rs1) || writes_load(lb, s.rs1));
    h2 = s.use_rs2 && (s.rs2 != '0) && (writes_load(la, s.rs2) || writes_load(lb, s.rs2));
    return h1 || h2;
  endfunction

  function automatic lane_t to_lane(slot_t s);
    return '{valid: 1'b1, instr: s.instr, itype: s.itype, rd: s.rd, we: s.we};
  endfunction

  state_t         state_q, state_d;
  lane_t          lane_a_q, lane_a_d, lane_b_q, lane_b_d;
  slot_t          hold_q, hold_d;
  hazard_signal_t haz_a_q, haz_a_d, haz_b_q, haz_b_d;
  logic [15:0]    bubble_cnt_q;
  slot_t          slot_a, slot_b;
  logic           a_hit, b_hit, hold_hit;
  logic           b_reads_a, waw, a_ctrl, mem_conflict, split;
  logic           issued, pending, bubble;

  assign slot_a = '{a_instr, a_type, a_rd, a_rs1, a_rs2, a_use_rs1, a_use_rs2, a_we};
  assign slot_b = '{b_instr, b_type, b_rd, b_rs1, b_rs2, b_use_rs1, b_use_rs2, b_we};

  assign a_hit    = load_hit(slot_a, lane_a_q, lane_b_q);
  assign b_hit    = load_hit(slot_b, lane_a_q, lane_b_q);
  assign hold_hit = load_hit(hold_q, lane_a_q, lane_b_q);

  assign b_reads_a    = a_we && (a_rd != '0) &&
                        ((b_use_rs1 && (b_rs1 == a_rd)) || (b_use_rs2 && (b_rs2 == a_rd)));
  assign waw          = a_we && b_we && (a_rd == b_rd) && (a_rd != '0);
  assign a_ctrl       = a_type inside {B_TYPE_i, JAL_i, JALR_i, ECALL_i};
  assign mem_conflict = (a_type inside {LOAD_i, S_TYPE_i}) && (b_type inside {LOAD_i, S_TYPE_i});
  assign split        = b_reads_a || waw || a_ctrl || mem_conflict;

  assign in_ready = iss_ready && !flush && (state_q == PAIR) && !a_hit;

  always_comb begin
    // NOTE: every target is given a default first so no path through this block infers a latch.
    state_d  = state_q;
    lane_a_d = lane_a_q;
    lane_b_d = lane_b_q;
    haz_a_d  = haz_a_q;
    haz_b_d  = haz_b_q;
    hold_d   = hold_q;
    issued   = 1'b0;
    pending  = 1'b0;
    if (flush) begin
      state_d        = PAIR;
      lane_a_d.valid = 1'b0;
      lane_b_d.valid = 1'b0;
      haz_a_d        = NONE_h;
      haz_b_d        = NONE_h;
      hold_d         = SLOT_RST;
    end else if (iss_ready) begin
      lane_a_d.valid = 1'b0;
      lane_b_d.valid = 1'b0;
      haz_a_d        = NONE_h;
      haz_b_d        = NONE_h;
      case (state_q)
        PAIR: begin
          if (in_valid) begin
            pending = 1'b1;
            if (a_hit) begin
              haz_a_d = A_STALL;
              haz_b_d = STALL_FROM_A;
            end else begin
              issued   = 1'b1;
              lane_a_d = to_lane(slot_a);
              if (b_hit || split) begin
                hold_d  = slot_b;
                state_d = HOLD_B;
                if (b_hit) haz_b_d = B_STALL;
                else       haz_b_d = STALL_FROM_A;
              end else begin
                lane_b_d = to_lane(slot_b);
              end
            end
          end
        end
        HOLD_B: begin
          pending = 1'b1;
          // Lanes were just cleared or hold A, so a held-B hit clears after one bubble.
          if (hold_hit) begin
            haz_b_d = B_STALL;
          end else begin
            issued   = 1'b1;
            lane_b_d = to_lane(hold_q);
            state_d  = PAIR;
          end
        end
        default: state_d = PAIR;
      endcase
    end
  end

  assign bubble = pending && !issued;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= PAIR;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the hold register is reset too, so a reset mid-split discards the parked B.
    if (!rst_n) begin
      lane_a_q     <= LANE_RST;
      lane_b_q     <= LANE_RST;
      hold_q       <= SLOT_RST;
      haz_a_q      <= NONE_h;
      haz_b_q      <= NONE_h;
      bubble_cnt_q <= '0;
    end else begin
      lane_a_q <= lane_a_d;
      lane_b_q <= lane_b_d;
      hold_q   <= hold_d;
      haz_a_q  <= haz_a_d;
      haz_b_q  <= haz_b_d;
      if (bubble && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign iss_a_valid = lane_a_q.valid;
  assign iss_a_instr = lane_a_q.instr;
  assign iss_a_type  = lane_a_q.itype;
  assign iss_a_rd    = lane_a_q.rd;
  assign iss_a_we    = lane_a_q.we;
  assign iss_b_valid = lane_b_q.valid;
  assign iss_b_instr = lane_b_q.instr;
  assign iss_b_type  = lane_b_q.itype;
  assign iss_b_rd    = lane_b_q.rd;
  assign iss_b_we    = lane_b_q.we;
  assign hazard_a    = haz_a_q;
  assign hazard_b    = haz_b_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule
